fir_stream_sequencer: RTL and testbench

Frame-level sequencer for the bit-serial FIR path: counts received serial bits into words, fires the deserializer-valid and FIR-enable strobes, waits out the FIR latency, then loads and paces the serializer bit by bit. It buffers one pending word while a transmit is in flight and flags overrun when a second word arrives. It sits alongside the deserializer, fir_filter and serializer instances and replaces free-running enable wiring with explicit per-word scheduling.

---
 rtl/fir_stream_sequencer_if.sv | 25 ++
 rtl/fir_stream_sequencer.sv | 170 +++++++++++++++++
 tb/tb_fir_stream_sequencer.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/fir_stream_sequencer_if.sv
// Control/strobe bundle between the frame sequencer and whoever drives it.
// The master drives enable, RX strobes and error clear; the slave returns the schedule strobes and status.
interface fir_stream_sequencer_if;
    logic i_en;
    logic i_rx_bit;
    logic i_rx_sync;
    logic i_clr_err;
    logic o_des_valid;
    logic o_fir_en;
    logic o_ser_load;
    logic o_ser_shift;
    logic o_tx_end;
    logic o_busy;
    logic o_overrun;

    modport master (
        output i_en, i_rx_bit, i_rx_sync, i_clr_err,
        input  o_des_valid, o_fir_en, o_ser_load, o_ser_shift, o_tx_end, o_busy, o_overrun
    );

    modport slave (
        input  i_en, i_rx_bit, i_rx_sync, i_clr_err,
        output o_des_valid, o_fir_en, o_ser_load, o_ser_shift, o_tx_end, o_busy, o_overrun
    );
endinterface

// File: rtl/fir_stream_sequencer.sv
// Per-word scheduler for the bit-serial FIR path: RX word counting, FIR enable, latency wait,
// serializer load and bit pacing, with a one-deep pending word and a sticky overrun flag.
module fir_stream_sequencer #(
    parameter int DATA_WIDTH  = 24,
    parameter int FIR_LATENCY = 2,
    parameter int TX_DIV      = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    fir_stream_sequencer_if.slave bus
);
    localparam int RXW = $clog2(DATA_WIDTH);
    localparam int BCW = $clog2(DATA_WIDTH);
    localparam int WW  = $clog2(FIR_LATENCY + 1);
    localparam int BW  = $clog2(TX_DIV + 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FIR_WAIT = 2'd1,
        LOAD     = 2'd2,
        TX       = 2'd3
    } state_t;

    state_t           state_r, state_nxt;
    logic [RXW-1:0]   rx_cnt_r, rx_cnt_nxt;
    logic [WW-1:0]    wait_r, wait_nxt;
    logic [BW-1:0]    baud_r, baud_nxt;
    logic [BCW-1:0]   bit_r, bit_nxt;
    logic             pend_r, pend_nxt;
    logic             word_done_s, dispatch_s, load_s, shift_s, end_s, ovr_s;

    logic des_valid_r, fir_en_r, ser_load_r, ser_shift_r, tx_end_r, busy_r;
    logic ovr_evt_r, overrun_r;

    // RX bit counter; sync realigns, and a coincident bit becomes bit 0 of the new word.
    always_comb begin
        rx_cnt_nxt  = rx_cnt_r;
        word_done_s = 1'b0;
        if (bus.i_en) begin
            if (bus.i_rx_sync) begin
                rx_cnt_nxt = bus.i_rx_bit ? RXW'(1) : RXW'(0);
            end else if (bus.i_rx_bit) begin
                if (rx_cnt_r == RXW'(DATA_WIDTH - 1)) begin
                    rx_cnt_nxt  = RXW'(0);
                    word_done_s = 1'b1;
                end else begin
                    rx_cnt_nxt = rx_cnt_r + RXW'(1);
                end
            end else begin
                rx_cnt_nxt = rx_cnt_r;
            end
        end else begin
            rx_cnt_nxt = rx_cnt_r;
        end
    end

    // The FSM runs one cycle ahead of the registered strobes it produces.
    always_comb begin
        state_nxt  = state_r;
        wait_nxt   = wait_r;
        baud_nxt   = baud_r;
        bit_nxt    = bit_r;
        pend_nxt   = pend_r;
        dispatch_s = 1'b0;
        load_s     = 1'b0;
        shift_s    = 1'b0;
        end_s      = 1'b0;
        ovr_s      = 1'b0;
        if (bus.i_en) begin
            case (state_r)
                IDLE: begin
                    if (word_done_s || pend_r) begin
                        dispatch_s = 1'b1;
                        wait_nxt   = WW'(0);
                        state_nxt  = (FIR_LATENCY == 1) ? LOAD : FIR_WAIT;
                        pend_nxt   = word_done_s && pend_r;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
                FIR_WAIT: begin
                    if (wait_r == WW'(FIR_LATENCY - 2)) begin
                        state_nxt = LOAD;
                    end else begin
                        wait_nxt = wait_r + WW'(1);
                    end
                end
                LOAD: begin
                    load_s    = 1'b1;
                    baud_nxt  = BW'(0);
                    bit_nxt   = BCW'(0);
                    state_nxt = TX;
                end
                TX: begin
                    if (baud_r == BW'(TX_DIV - 1)) begin
                        shift_s  = 1'b1;
                        baud_nxt = BW'(0);
                        if (bit_r == BCW'(DATA_WIDTH - 1)) begin
                            end_s     = 1'b1;
                            state_nxt = IDLE;
                        end else begin
                            bit_nxt = bit_r + BCW'(1);
                        end
                    end else begin
                        baud_nxt = baud_r + BW'(1);
                    end
                end
                default: state_nxt = IDLE;
            endcase
            if (word_done_s && (state_r != IDLE)) begin
                pend_nxt = 1'b1;
            end else begin
                pend_nxt = pend_nxt;
            end
            ovr_s = word_done_s && pend_r && !dispatch_s;
        end else begin
            state_nxt = state_r;
        end
    end

    // State, counters and registered outputs; enable low freezes everything and zeroes pulses.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_r     <= IDLE;
            rx_cnt_r    <= RXW'(0);
            wait_r      <= WW'(0);
            baud_r      <= BW'(0);
            bit_r       <= BCW'(0);
            pend_r      <= 1'b0;
            des_valid_r <= 1'b0;
            fir_en_r    <= 1'b0;
            ser_load_r  <= 1'b0;
            ser_shift_r <= 1'b0;
            tx_end_r    <= 1'b0;
            busy_r      <= 1'b0;
            ovr_evt_r   <= 1'b0;
            overrun_r   <= 1'b0;
        end else if (bus.i_en) begin
            state_r     <= state_nxt;
            rx_cnt_r    <= rx_cnt_nxt;
            wait_r      <= wait_nxt;
            baud_r      <= baud_nxt;
            bit_r       <= bit_nxt;
            pend_r      <= pend_nxt;
            des_valid_r <= word_done_s;
            fir_en_r    <= dispatch_s;
            ser_load_r  <= load_s;
            ser_shift_r <= shift_s;
            tx_end_r    <= end_s;
            busy_r      <= (state_r != IDLE) || (state_nxt != IDLE);
            ovr_evt_r   <= ovr_s;
            // A new overrun in the clear cycle wins over the clear.
            overrun_r   <= ovr_evt_r || (overrun_r && !bus.i_clr_err);
        end else begin
            des_valid_r <= 1'b0;
            fir_en_r    <= 1'b0;
            ser_load_r  <= 1'b0;
            ser_shift_r <= 1'b0;
            tx_end_r    <= 1'b0;
        end
    end

    assign bus.o_des_valid = des_valid_r;
    assign bus.o_fir_en    = fir_en_r;
    assign bus.o_ser_load  = ser_load_r;
    assign bus.o_ser_shift = ser_shift_r;
    assign bus.o_tx_end    = tx_end_r;
    assign bus.o_busy      = busy_r;
    assign bus.o_overrun   = overrun_r;
endmodule

// File: tb/tb_fir_stream_sequencer.sv
// Bench for fir_stream_sequencer: two parameterisations driven by directed and random stimulus,
// compared cycle by cycle against a schedule model derived from the word timing formulas.
module tb_fir_stream_sequencer;
    localparam int N = 1600;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fir_stream_sequencer_if bus_a ();
    fir_stream_sequencer_if bus_b ();

    fir_stream_sequencer #(.DATA_WIDTH(24), .FIR_LATENCY(2), .TX_DIV(1)) dut_a (
        .i_clk(clk), .i_rst(rst), .bus(bus_a)
    );
    fir_stream_sequencer #(.DATA_WIDTH(4), .FIR_LATENCY(1), .TX_DIV(3)) dut_b (
        .i_clk(clk), .i_rst(rst), .bus(bus_b)
    );

    logic [6:0] obs_a, obs_b;
    assign obs_a = {bus_a.o_des_valid, bus_a.o_fir_en, bus_a.o_ser_load, bus_a.o_ser_shift,
                    bus_a.o_tx_end, bus_a.o_busy, bus_a.o_overrun};
    assign obs_b = {bus_b.o_des_valid, bus_b.o_fir_en, bus_b.o_ser_load, bus_b.o_ser_shift,
                    bus_b.o_tx_end, bus_b.o_busy, bus_b.o_overrun};

    logic       st_en [N];
    logic       st_bit [N];
    logic       st_sync [N];
    logic       st_clr [N];
    logic       st_rst [N];
    logic [6:0] exp_v [2][N+1];

    int vectors = 0;
    int miscompares = 0;

    task automatic check_eq(input string tag, input logic [6:0] obs, input logic [6:0] expv);
        vectors++;
        if (obs !== expv) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b", tag, obs, expv);
        end
    endtask

    // Schedule model: a dispatch at enabled cycle s loads at s+FL, shifts every TXD cycles after that,
    // and ends at s+FL+DW*TXD; outputs appear one clock after the enabled cycle that decides them.
    task automatic build_model(input int c, input int dw, input int fl, input int txd);
        int rx_pos, e, start, end_e, rel;
        bit has_txn, pending, ovr_prev, overrun, busy, wd, disp, ovr, load, shift, tend;
        rx_pos = 0; e = 0; start = 0; end_e = 0;
        has_txn = 1'b0; pending = 1'b0; ovr_prev = 1'b0; overrun = 1'b0; busy = 1'b0;
        exp_v[c][0] = 7'd0;
        for (int t = 0; t < N; t++) begin
            if (st_rst[t]) begin
                rx_pos = 0; has_txn = 1'b0; pending = 1'b0;
                ovr_prev = 1'b0; overrun = 1'b0; busy = 1'b0;
                exp_v[c][t+1] = 7'd0;
            end else if (!st_en[t]) begin
                exp_v[c][t+1] = {5'd0, busy, overrun};
            end else begin
                wd = 1'b0;
                if (st_sync[t]) begin
                    rx_pos = st_bit[t] ? 1 : 0;
                end else if (st_bit[t]) begin
                    rx_pos = (rx_pos + 1) % dw;
                    wd = (rx_pos == 0);
                end
                disp = !(has_txn && e <= end_e) && (wd || pending);
                ovr  = wd && pending && !disp;
                if (disp) begin
                    start = e; end_e = e + fl + dw * txd; has_txn = 1'b1;
                    pending = wd && pending;
                end else if (wd) begin
                    pending = 1'b1;
                end
                busy  = has_txn && e >= start && e <= end_e;
                rel   = e - start;
                load  = busy && rel == fl;
                shift = busy && rel > fl && ((rel - fl) % txd == 0);
                tend  = busy && e == end_e;
                overrun  = ovr_prev || (overrun && !st_clr[t]);
                ovr_prev = ovr;
                exp_v[c][t+1] = {wd, disp, load, shift, tend, busy, overrun};
                e++;
            end
        end
    endtask

    task automatic drive(input int t);
        rst = st_rst[t];
        bus_a.i_en = st_en[t];     bus_b.i_en = st_en[t];
        bus_a.i_rx_bit = st_bit[t]; bus_b.i_rx_bit = st_bit[t];
        bus_a.i_rx_sync = st_sync[t]; bus_b.i_rx_sync = st_sync[t];
        bus_a.i_clr_err = st_clr[t]; bus_b.i_clr_err = st_clr[t];
    endtask

    initial begin
        for (int t = 0; t < N; t++) begin
            st_rst[t] = (t < 3) || (t == 300) || (t == 301);
            st_en[t] = 1'b1; st_bit[t] = 1'b0; st_sync[t] = 1'b0; st_clr[t] = 1'b0;
            if (t >= 7 && t <= 30) st_bit[t] = 1'b1;
            if (t >= 80 && t < 300) begin
                st_bit[t] = 1'b1;
                st_en[t]  = !(t >= 150 && t <= 154);
                st_clr[t] = (t == 200) || (t >= 260 && t % 3 == 0);
            end
            if (t >= 310 && t <= 333) st_bit[t] = 1'b1;
            if (t >= 350 && t <= 354) st_en[t] = 1'b0;
            if (t >= 405 && t <= 438) st_bit[t] = 1'b1;
            if (t == 415) st_sync[t] = 1'b1;
            if (t >= 500) begin
                st_rst[t]  = ($urandom_range(0, 299) == 0);
                st_en[t]   = ($urandom_range(0, 7) != 0);
                st_bit[t]  = ($urandom_range(0, 3) != 0);
                st_sync[t] = ($urandom_range(0, 63) == 0);
                st_clr[t]  = ($urandom_range(0, 15) == 0);
            end
        end
        build_model(0, 24, 2, 1);
        build_model(1, 4, 1, 3);

        for (int t = 0; t < N; t++) begin
            drive(t);
            if (t > 0 && st_rst[t] && !st_rst[t-1]) begin
                #1;
                check_eq($sformatf("rst_async_a@%0d", t), obs_a, 7'd0);
                check_eq($sformatf("rst_async_b@%0d", t), obs_b, 7'd0);
            end
            @(posedge clk);
            #1;
            check_eq($sformatf("a@%0d", t + 1), obs_a, exp_v[0][t+1]);
            check_eq($sformatf("b@%0d", t + 1), obs_b, exp_v[1][t+1]);
            case (t + 1)
                30: check_eq("plan_busy30", 7'(bus_a.o_busy), 7'd0);
                31: check_eq("plan_des_fir31", 7'({bus_a.o_des_valid, bus_a.o_fir_en}), 7'd3);
                33: check_eq("plan_load33", 7'(bus_a.o_ser_load), 7'd1);
                34: check_eq("plan_shift34", 7'(bus_a.o_ser_shift), 7'd1);
                57: check_eq("plan_end57", 7'({bus_a.o_tx_end, bus_a.o_busy}), 7'd3);
                58: check_eq("plan_idle58", 7'({bus_a.o_tx_end, bus_a.o_busy}), 7'd0);
                default: ;
            endcase
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
